// File: rtl/ri_inst_loader.sv
// Instruction RAM loader for RI_CPU: packs an MSB-first byte stream into 32-bit
// words, writes them from address 0 and holds the CPU in reset until done.
// Optional checksum trailer: define RI_LOADER_CHECKSUM_EN.
module ri_inst_loader #(
  parameter int ADDR_W   = 6,
  parameter int RST_HOLD = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_word_count,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_state
);

  // Handshake: a byte moves on a rising edge where i_byte_valid and
  // o_byte_ready are both 1; o_byte_ready is registered from the next state.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5,
    CHK   = 3'd6
  } state_t;

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(1) << ADDR_W;

  state_t          r_state;
  state_t          w_nxt;
  logic [1:0]      r_byte_idx;
  logic [ADDR_W:0] r_word_idx;
  logic [ADDR_W:0] r_count;
  logic [23:0]     r_word;
  logic [HW-1:0]   r_hold_cnt;
  logic            w_xfer;
  logic            w_start_ok;
  logic            w_last_byte;
  logic [31:0]     w_word_next;
  state_t          w_after_data;
`ifdef RI_LOADER_CHECKSUM_EN
  logic [31:0]     r_csum;
`endif

  assign w_xfer      = o_byte_ready & i_byte_valid;
  assign w_start_ok  = i_start & (r_state == IDLE || r_state == RUN || r_state == ERR);
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_word_next = {r_word, i_byte_in};
  assign o_state     = r_state;

`ifdef RI_LOADER_CHECKSUM_EN
  assign w_after_data = CHK;
`else
  assign w_after_data = HOLD;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE, RUN, ERR: begin
        if (i_start) begin
          if (i_word_count == '0)            w_nxt = w_after_data;
          else if (i_word_count > MAX_WORDS) w_nxt = ERR;
          else                               w_nxt = LOAD;
        end
      end
      LOAD:  if (w_xfer && w_last_byte) w_nxt = WRITE;
      WRITE: w_nxt = ((r_word_idx + (ADDR_W+1)'(1)) == r_count) ? w_after_data : LOAD;
      HOLD:  if (r_hold_cnt == HW'(RST_HOLD - 1)) w_nxt = RUN;
`ifdef RI_LOADER_CHECKSUM_EN
      CHK:   if (w_xfer && w_last_byte) w_nxt = (w_word_next == r_csum) ? HOLD : ERR;
`endif
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_count      <= '0;
      r_word       <= '0;
      r_hold_cnt   <= '0;
      o_byte_ready <= 1'b0;
      o_ram_we     <= 1'b0;
      o_ram_addr   <= '0;
      o_ram_wdata  <= '0;
      o_cpu_rst    <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
`ifdef RI_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_nxt;
      o_byte_ready <= (w_nxt == LOAD) || (w_nxt == CHK);
      o_ram_we     <= (w_nxt == WRITE);
      o_cpu_rst    <= (w_nxt != RUN);
      o_busy       <= (w_nxt == LOAD) || (w_nxt == WRITE) || (w_nxt == HOLD) || (w_nxt == CHK);
      o_done       <= (w_nxt == RUN);
      o_err        <= (w_nxt == ERR);
      r_hold_cnt   <= (r_state == HOLD) ? r_hold_cnt + HW'(1) : '0;

      if (w_start_ok) begin
        r_count    <= i_word_count;
        r_word_idx <= '0;
        r_byte_idx <= '0;
        r_word     <= '0;
`ifdef RI_LOADER_CHECKSUM_EN
        r_csum     <= '0;
`endif
      end else begin
        if (w_xfer) begin
          r_word     <= w_word_next[23:0];
          r_byte_idx <= r_byte_idx + 2'd1;
        end
        // Address and data are captured on the edge that accepts the 4th byte
        // so the write pulse lands in the very next cycle.
        if (r_state == LOAD && w_nxt == WRITE) begin
          o_ram_addr  <= r_word_idx[ADDR_W-1:0];
          o_ram_wdata <= w_word_next;
`ifdef RI_LOADER_CHECKSUM_EN
          r_csum      <= r_csum ^ w_word_next;
`endif
        end
        if (r_state == WRITE) r_word_idx <= r_word_idx + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_ri_inst_loader.sv
// Directed bench for ri_inst_loader: stimulus pushes expected RAM writes into
// a queue, a negedge monitor pops and compares on every ram_we pulse.
module tb_ri_inst_loader;

  localparam int ADDR_W = 6;
  localparam int W = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state;

  logic [W-1:0] exp_q[$];
  logic [31:0]  wbuf [0:3];
  int n_checks = 0;
  int n_fail   = 0;

  ri_inst_loader #(.ADDR_W(ADDR_W), .RST_HOLD(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_word_count(word_count),
    .i_byte_in(byte_in), .i_byte_valid(byte_valid), .o_byte_ready(byte_ready),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .o_cpu_rst(cpu_rst), .o_busy(busy), .o_done(done), .o_err(err), .o_state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && ram_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {26'd0, ram_addr, ram_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("ram_write", {26'd0, ram_addr, ram_wdata}, {26'd0, e});
      end
      check("ready_low_in_write", byte_ready, 0);
      check("busy_in_write", busy, 1);
    end
  end

  // driver tasks
  task automatic do_start(input logic [ADDR_W:0] cnt);
    start = 1'b1;
    word_count = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int t;
    if (toggle) begin
      byte_valid = 1'b0;
      byte_in = 8'hEE;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 0, 1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in = 8'hEE;
    check("busy_during_load", busy, 1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], toggle);
  endtask

  task automatic run_load(input int n, input bit toggle);
    logic [31:0] x;
    logic [5:0]  a;
    x = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = 6'(i);
      exp_q.push_back({a, wbuf[i]});
      x = x ^ wbuf[i];
    end
    for (int i = 0; i < n; i++) send_word(wbuf[i], toggle);
`ifdef RI_LOADER_CHECKSUM_EN
    send_word(x, toggle);
`endif
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check(name, done, 1);
    check({name, "_cpu_rst"}, cpu_rst, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    word_count = '0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_state", state, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cpu_rst", cpu_rst, 1);

    // two words, continuous valid, exact hold timing
    wbuf[0] = 32'h2001_0005;
    wbuf[1] = 32'h3C02_1234;
    do_start(7'd2);
    check("load_busy", busy, 1);
    run_load(2, 1'b0);
`ifndef RI_LOADER_CHECKSUM_EN
    check("write_latency", ram_we, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_cpu_rst", cpu_rst, 1);
      check("hold_busy", busy, 1);
    end
    @(negedge clk);
    check("release_cpu_rst", cpu_rst, 0);
    check("release_done", done, 1);
    check("release_busy", busy, 0);
`endif
    wait_done("t1_done");

    // same load, valid toggling
    do_start(7'd2);
    run_load(2, 1'b1);
    wait_done("t2_done");

    // overflow count
    do_start(7'd65);
    check("ovf_err", err, 1);
    check("ovf_cpu_rst", cpu_rst, 1);
    check("ovf_done", done, 0);
    repeat (3) @(negedge clk);
    check("ovf_stays_err", err, 1);
    wbuf[0] = 32'h1122_3344;
    do_start(7'd1);
    check("recover_err_clear", err, 0);
    run_load(1, 1'b0);
    wait_done("t3_done");

    // reset mid-load after 2 bytes of word 1
    do_start(7'd3);
    exp_q.push_back({6'd0, 32'hAABB_CCDD});
    send_word(32'hAABB_CCDD, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", byte_ready, 0);
    check("midrst_state", state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wbuf[0] = 32'h0102_0304;
    wbuf[1] = 32'hDEAD_BEEF;
    wbuf[2] = 32'h8000_0001;
    do_start(7'd3);
    do_start(7'd65);
    check("start_ignored_in_load", err, 0);
    run_load(3, 1'b0);
    wait_done("t4_done");

    // restart from RUN
    check("run_cpu_rst_low", cpu_rst, 0);
    do_start(7'd1);
    check("restart_cpu_rst", cpu_rst, 1);
    check("restart_done_low", done, 0);
    wbuf[0] = 32'h0000_0000;
    run_load(1, 1'b0);
    wait_done("t5_done");

    // zero-word load
    do_start(7'd0);
    check("zero_busy", busy, 1);
    check("zero_cpu_rst", cpu_rst, 1);
`ifndef RI_LOADER_CHECKSUM_EN
    check("zero_state_hold", state, 3);
`endif
    run_load(0, 1'b0);
    wait_done("t6_done");

`ifdef RI_LOADER_CHECKSUM_EN
    // explicit checksum bytes 1C 03 12 31 good, 1C 03 12 30 bad
    do_start(7'd2);
    exp_q.push_back({6'd0, 32'h2001_0005});
    exp_q.push_back({6'd1, 32'h3C02_1234});
    send_word(32'h2001_0005, 1'b0);
    send_word(32'h3C02_1234, 1'b0);
    send_word(32'h1C03_1231, 1'b0);
    wait_done("csum_good_done");
    check("csum_good_err", err, 0);
    do_start(7'd2);
    exp_q.push_back({6'd0, 32'h2001_0005});
    exp_q.push_back({6'd1, 32'h3C02_1234});
    send_word(32'h2001_0005, 1'b0);
    send_word(32'h3C02_1234, 1'b0);
    send_word(32'h1C03_1230, 1'b0);
    check("csum_bad_err", err, 1);
    check("csum_bad_cpu_rst", cpu_rst, 1);
    check("csum_bad_state", state, 5);
`endif

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
